// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle floating-point adder for packed {sign, exp, fraction}
// words. One operation in flight; aligns, adds, normalises and rounds through
// an iterative FSM that shifts one bit per cycle. Denormals flush to zero.
// Optional feature macro: FP_ADD_RNE_EN selects round-to-nearest-even;
// without it the result is truncated (same latency either way).
module fp_add_seq #(
    parameter int precision     = 32,
    parameter int exponent_size = 8,
    parameter int mantissa_size = 23,
    parameter int exp_bias      = 127
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [precision-1:0] a,
    input  logic [precision-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [precision-1:0] sum,
    output logic                 overflow
);

    // Working mantissa: {carry, hidden, fraction, guard, round, sticky}.
    localparam int W  = mantissa_size + 5;
    // Two spare exponent bits absorb the carry and rounding increments.
    localparam int EW = exponent_size + 2;
    localparam logic [EW-1:0] EXP_ONE       = EW'(1);
    localparam logic [EW-1:0] EXP_MAX       = EW'(2 * exp_bias + 1);
    localparam logic [EW-1:0] COLLAPSE_DIFF = EW'(mantissa_size + 3);
    localparam logic [precision-1:0] CANON_NAN =
        {1'b0, {exponent_size{1'b1}}, 1'b1, {(mantissa_size-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

    state_t                 r_state;
    logic                   r_in_ready, r_out_valid, r_overflow;
    logic [precision-1:0]   r_sum;
    logic                   r_big_sign, r_small_sign;
    logic [EW-1:0]          r_big_exp, r_small_exp;
    logic [W-1:0]           r_big_man, r_small_man;

    // Operand field decode.
    logic                     w_a_sign, w_b_sign;
    logic [exponent_size-1:0] w_a_exp, w_b_exp;
    logic [mantissa_size-1:0] w_a_frac, w_b_frac;
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_special;

    assign {w_a_sign, w_a_exp, w_a_frac} = a;
    assign {w_b_sign, w_b_exp, w_b_frac} = b;
    assign w_a_zero  = (w_a_exp == '0);
    assign w_b_zero  = (w_b_exp == '0);
    assign w_a_inf   = (w_a_exp == '1) && (w_a_frac == '0);
    assign w_b_inf   = (w_b_exp == '1) && (w_b_frac == '0);
    assign w_a_nan   = (w_a_exp == '1) && (w_a_frac != '0);
    assign w_b_nan   = (w_b_exp == '1) && (w_b_frac != '0);
    assign w_special = w_a_zero | w_b_zero | w_a_inf | w_b_inf | w_a_nan | w_b_nan;

    logic [W-1:0] w_a_man, w_b_man;
    assign w_a_man = {1'b0, 1'b1, w_a_frac, 3'b000};
    assign w_b_man = {1'b0, 1'b1, w_b_frac, 3'b000};

    // Result for zero / infinity / NaN operands, resolved without the datapath.
    logic [precision-1:0] w_special_sum;
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_special_sum = '0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_sign != w_b_sign)))
            w_special_sum = CANON_NAN;
        else if (w_a_inf)
            w_special_sum = a;
        else if (w_b_inf)
            w_special_sum = b;
        else if (w_a_zero && w_b_zero)
            w_special_sum = {w_a_sign & w_b_sign, {(precision-1){1'b0}}};
        else if (w_a_zero)
            w_special_sum = b;
        else
            w_special_sum = a;
    end

    // Alignment and magnitude add/subtract.
    logic [EW-1:0] w_exp_diff;
    logic          w_big_ge;
    logic [W-1:0]  w_mag;
    logic          w_res_sign;
    assign w_exp_diff = r_big_exp - r_small_exp;
    assign w_big_ge   = (r_big_man >= r_small_man);
    assign w_mag      = (r_big_sign == r_small_sign) ? r_big_man + r_small_man :
                        w_big_ge ? r_big_man - r_small_man : r_small_man - r_big_man;
    assign w_res_sign = (r_big_sign == r_small_sign || w_big_ge) ? r_big_sign : r_small_sign;

    // Rounding of the normalised significand {hidden, fraction}.
    logic [mantissa_size:0]   w_sig;
    logic                     w_round_inc;
    logic [mantissa_size+1:0] w_sig_rnd;
    logic [EW-1:0]            w_rnd_exp;
    logic [mantissa_size-1:0] w_rnd_frac;
    assign w_sig = r_big_man[W-2:3];
`ifdef FP_ADD_RNE_EN
    assign w_round_inc = r_big_man[2] & (r_big_man[1] | r_big_man[0] | w_sig[0]);
`else
    assign w_round_inc = 1'b0;
`endif
    assign w_sig_rnd  = {1'b0, w_sig} + {{(mantissa_size+1){1'b0}}, w_round_inc};
    // A rounding carry leaves 1.000...0, so the stored fraction becomes zero.
    assign w_rnd_exp  = r_big_exp + {{(EW-1){1'b0}}, w_sig_rnd[mantissa_size+1]};
    assign w_rnd_frac = w_sig_rnd[mantissa_size+1] ? '0 : w_sig_rnd[mantissa_size-1:0];

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_overflow   <= 1'b0;
            r_sum        <= '0;
            r_big_sign   <= 1'b0;
            r_small_sign <= 1'b0;
            r_big_exp    <= '0;
            r_small_exp  <= '0;
            r_big_man    <= '0;
            r_small_man  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_special) begin
                            r_sum       <= w_special_sum;
                            r_overflow  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            if (w_a_exp >= w_b_exp) begin
                                r_big_sign   <= w_a_sign;
                                r_big_exp    <= {2'b00, w_a_exp};
                                r_big_man    <= w_a_man;
                                r_small_sign <= w_b_sign;
                                r_small_exp  <= {2'b00, w_b_exp};
                                r_small_man  <= w_b_man;
                            end else begin
                                r_big_sign   <= w_b_sign;
                                r_big_exp    <= {2'b00, w_b_exp};
                                r_big_man    <= w_b_man;
                                r_small_sign <= w_a_sign;
                                r_small_exp  <= {2'b00, w_a_exp};
                                r_small_man  <= w_a_man;
                            end
                            r_state <= S_ALIGN;
                        end
                    end
                end
                S_ALIGN: begin
                    if (w_exp_diff == '0) begin
                        r_state <= S_ADD;
                    end else if (w_exp_diff > COLLAPSE_DIFF) begin
                        // Entire small operand lies below the sticky position.
                        r_small_man <= {{(W-1){1'b0}}, 1'b1};
                        r_small_exp <= r_big_exp;
                    end else begin
                        r_small_man <= {1'b0, r_small_man[W-1:2], r_small_man[1] | r_small_man[0]};
                        r_small_exp <= r_small_exp + EXP_ONE;
                    end
                end
                S_ADD: begin
                    if (w_mag == '0) begin
                        r_sum       <= '0;
                        r_overflow  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_big_man  <= w_mag;
                        r_big_sign <= w_res_sign;
                        r_state    <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_big_man[W-1]) begin
                        r_big_man <= {1'b0, r_big_man[W-1:2], r_big_man[1] | r_big_man[0]};
                        r_big_exp <= r_big_exp + EXP_ONE;
                        r_state   <= S_ROUND;
                    end else if (r_big_man[W-2]) begin
                        r_state <= S_ROUND;
                    end else if (r_big_exp <= EXP_ONE) begin
                        // Result would be denormal: flush to signed zero.
                        r_sum       <= {r_big_sign, {(precision-1){1'b0}}};
                        r_overflow  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_big_man <= {r_big_man[W-2:0], 1'b0};
                        r_big_exp <= r_big_exp - EXP_ONE;
                    end
                end
                S_ROUND: begin
                    if (w_rnd_exp >= EXP_MAX) begin
                        r_sum      <= {r_big_sign, {exponent_size{1'b1}}, {mantissa_size{1'b0}}};
                        r_overflow <= 1'b1;
                    end else begin
                        r_sum      <= {r_big_sign, w_rnd_exp[exponent_size-1:0], w_rnd_frac};
                        r_overflow <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: directed cases plus randomized operands,
// compared against an exact-integer reference model through a scoreboard.
module tb_fp_add_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, overflow;
    logic [31:0] a, b, sum;

    int n_tests = 0;
    int n_fail  = 0;
    bit manual_ready = 1'b0;

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    fp_add_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: exact sum of the two operands as scaled integers, then one
    // rounding step. Returns {overflow, sum}.
    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        int          ex, ey, emin, p, e, sh;
        logic        sx, sy, sign;
        logic        x_nan, y_nan, x_inf, y_inf;
        longint      mx, my, s;
        logic [63:0] mag, sig, rem, half;
        sx = x[31]; sy = y[31];
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        x_nan = (ex == 255) && (x[22:0] != 0);
        y_nan = (ey == 255) && (y[22:0] != 0);
        x_inf = (ex == 255) && (x[22:0] == 0);
        y_inf = (ey == 255) && (y[22:0] == 0);
        if (x_nan || y_nan) return {1'b0, 32'h7FC00000};
        if (x_inf && y_inf) return (sx == sy) ? {1'b0, x} : {1'b0, 32'h7FC00000};
        if (x_inf) return {1'b0, x};
        if (y_inf) return {1'b0, y};
        if (ex == 0 && ey == 0) return {1'b0, sx & sy, 31'b0};
        if (ex == 0) return {1'b0, y};
        if (ey == 0) return {1'b0, x};
        emin = (ex < ey) ? ex : ey;
        mx = longint'({1'b1, x[22:0]}) << (ex - emin);
        my = longint'({1'b1, y[22:0]}) << (ey - emin);
        s  = (sx ? -mx : mx) + (sy ? -my : my);
        if (s == 0) return 33'd0;
        sign = (s < 0);
        mag  = sign ? 64'(-s) : 64'(s);
        p = 0;
        for (int i = 62; i >= 0; i--) begin
            if (mag[i]) begin p = i; break; end
        end
        e = emin + p - 23;
        if (e < 1) return {1'b0, sign, 31'b0};
        if (p > 23) begin
            sh   = p - 23;
            sig  = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
`ifdef FP_ADD_RNE_EN
            if (rem > half || (rem == half && sig[0])) sig = sig + 64'd1;
`else
            if (rem > mag) sig = 64'd0;  // truncation: remainder is discarded
            if (half == 64'd0) sig = 64'd0;
`endif
        end else begin
            sig = mag << (23 - p);
        end
        if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= 255) return {1'b1, sign, 8'hFF, 23'b0};
        return {1'b0, sign, 8'(e), sig[22:0]};
    endfunction

    // Background downstream backpressure, changed away from the sampling edge.
    always @(posedge clk) begin
        #2;
        if (!manual_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare each accepted result with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %h, expected no output", sum);
            end else begin
                e = sb_q.pop_front();
                check("sum", sum, e.sum);
                check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
            end
        end
    end

    // Issue one operation; optionally check the accept-to-out_valid latency.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input int exp_lat);
        logic [32:0] r;
        int          n;
        r = ref_add(ia, ib);
        @(negedge clk);
        a = ia; b = ib; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 300 cycles");
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back('{r[31:0], r[32]});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 300);
        if (!out_valid) begin
            n_tests++; n_fail++;
            $display("FAIL result_timeout: got out_valid=0, expected 1 within 300 cycles");
        end else if (exp_lat >= 0) begin
            check("latency", 32'(n), 32'(exp_lat));
        end
    endtask

    function automatic logic [31:0] rnd_fin(input int e);
        logic [31:0] r;
        r = $urandom;
        return {r[31], 8'(e), r[22:0]};
    endfunction

    function automatic logic [31:0] rnd_special();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0:       return {r[31], 8'h00, r[22:0]};
            1:       return {r[31], 8'hFF, 23'b0};
            default: return {r[31], 8'hFF, r[22:1], 1'b1};
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        int          ea, eb, mode, n;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        #12;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_sum", sum, 32'd0);
        check("reset_overflow", {31'b0, overflow}, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed cases.
        issue(32'h3F800000, 32'h3F800000, 5);
        issue(32'h40400000, 32'h3F000000, 7);
        issue(32'h3F800000, 32'hBF800000, -1);
        issue(32'h7F800000, 32'hFF800000, 1);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 5);
        issue(32'h00000000, 32'hC1230000, 1);
        issue(32'h80000001, 32'h80000000, 1);
        issue(32'h7FC12345, 32'h3F800000, 1);
        issue(32'h3F800000, 32'h32000000, 6);
        issue(32'h3FC00000, 32'hBF800000, 6);
        issue(32'h00800000, 32'h80C00000, -1);
        issue(32'h3F800000, 32'h33800000, -1);
        issue(32'h3F800000, 32'h33C00000, -1);

        // Backpressure: hold out_ready low, sum must stay put.
        @(negedge clk); #1;
        manual_ready = 1'b1; out_ready = 1'b0;
        issue(32'h40000000, 32'h40000000, 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_sum", sum, 32'h40800000);
            check("hold_valid", {31'b0, out_valid}, 32'd1);
        end
        @(posedge clk); #2; out_ready = 1'b1;
        @(posedge clk); #2; out_ready = 1'b0;
        @(negedge clk);
        check("post_hs_in_ready", {31'b0, in_ready}, 32'd1);
        check("post_hs_out_valid", {31'b0, out_valid}, 32'd0);
        manual_ready = 1'b0;

        // Reset asserted while the block is aligning.
        @(negedge clk);
        a = 32'h40400000; b = 32'h3A000000; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                check("stale_result", {31'b0, out_valid}, 32'd0);
                break;
            end
        end
        issue(32'h3F800000, 32'h3F800000, 5);

        // Randomized operands.
        for (int t = 0; t < 200; t++) begin
            mode = $urandom_range(0, 9);
            ea = $urandom_range(1, 254);
            eb = ea + $urandom_range(0, 72) - 36;
            if (eb < 1) eb = 1;
            if (eb > 254) eb = 254;
            ra = rnd_fin(ea);
            rb = rnd_fin(eb);
            case (mode)
                0: if ($urandom_range(0, 1) != 0) ra = rnd_special(); else rb = rnd_special();
                1, 2: begin
                    ra = rnd_fin($urandom_range(1, 6));
                    rb = rnd_fin($urandom_range(1, 6));
                end
                3: begin
                    ra = rnd_fin($urandom_range(250, 254));
                    rb = rnd_fin($urandom_range(250, 254));
                end
                9: rb = ra ^ 32'h80000000 ^ 32'($urandom_range(0, 15));
                default: ;
            endcase
            issue(ra, rb, -1);
        end

        n = 0;
        while (sb_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (sb_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: got %0d pending results, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_add_seq.md
# fp_add_seq

Multi-cycle floating-point adder that consumes the packed IEEE-754-style words produced by the int_to_fp converter and returns their sum. Operands arrive on a valid/ready handshake. The block aligns, adds, normalises and rounds through an iterative FSM, shifting one bit per cycle, and holds its result until the downstream stage accepts it. Denormals are flushed to zero, and one operation is in flight at a time.

## Interface
- `precision`, 32, total word width
- `exponent_size`, 8, exponent field width
- `mantissa_size`, 23, stored fraction width; `precision = 1 + exponent_size + mantissa_size`
- `exp_bias`, 127, exponent bias
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `in_valid`  in  1  operands `a`, `b` valid
- `in_ready`  out  1  block can accept operands
- `a`, `b`  in  precision  packed operands {sign, exp, fraction}
- `out_valid`  out  1  `sum` valid
- `out_ready`  in  1  downstream accepts `sum`
- `sum`  out  precision  packed result
- `overflow`  out  1  result saturated to infinity; valid with `out_valid`

## Operation
- Internal datapath: `mantissa_size+5` bits = {carry, hidden, fraction, guard, round, sticky}.
- FSM states:
  - IDLE: `in_ready=1`. On `in_valid`, capture the operands.
    - Special operands go to DONE with the result computed immediately.
    - Otherwise unpack, order the operands so the larger exponent is the big operand, and go to ALIGN.
- Special rules, evaluated in IDLE:
  - exp==0 means zero; the fraction is ignored (flush).
  - Either operand NaN, or +inf + -inf → `0x7FC00000` (canonical NaN).
  - One operand inf → that inf.
  - Both zero → sign = a.sign & b.sign.
  - One operand zero → the other operand, passed through unchanged.
- ALIGN:
  - Equal exponents → ADD.
  - Exponent difference > `mantissa_size+3` → small mantissa collapses to sticky=1 in one cycle, then ADD.
  - Otherwise, each cycle: shift the small mantissa right 1 bit (OR the shifted-out bit into sticky) and increment its exponent.
- ADD: same signs → add magnitudes; different signs → subtract the smaller magnitude from the larger. Result sign = sign of the larger magnitude. An exact-zero result → +0, go to DONE.
- NORM:
  - If carry=1: shift right 1 bit (sticky preserved), exp+1, → ROUND.
  - Else if hidden=1 → ROUND.
  - Else: shift left 1 bit, exp−1, stay. If exp would drop below 1, flush to signed zero and go to DONE.
- ROUND: rounding per Configuration.
  - A mantissa overflow from rounding renormalises (exp+1).
  - exp ≥ 255 → ±inf, `overflow=1`.
  - → DONE.
- DONE: `out_valid=1`; `sum` and `overflow` are stable. On `out_ready` → IDLE.
- `in_ready` is deasserted in every state except IDLE.

## Timing
- Reset (async, any state) values:
  - State IDLE.
  - `in_ready=1` once reset is released.
  - `out_valid=0`, `sum=0`, `overflow=0`.
  - All datapath registers zeroed.
  - Any in-flight operation is discarded.
- Handshakes complete on a rising edge with valid&ready high.
- Latency is counted from the accept edge (cycle 0):
  - Specials: `out_valid` at cycle 1.
  - Normal: `out_valid` at cycle 5 + A + L, where A = alignment shifts (0, 1 if collapsed, else exponent difference) and L = left-normalise shifts.
- `out_valid` holds indefinitely while `out_ready=0`; `sum` does not change.
- `in_ready` rises the cycle after the output handshake. There is no simultaneous output-accept/input-accept.
- Operand inputs are sampled only at the accept edge; later changes on `a`/`b` are ignored.

## Configuration
- `FP_ADD_RNE_EN` defined: round-to-nearest-even.
  - Increment when guard & (round | sticky | lsb).
- Undefined: truncate. Guard, round and sticky are discarded, and the ROUND state still costs 1 cycle, so latency is identical.

## Test plan
- a=`0x3F800000`, b=`0x3F800000` → `sum=0x40000000`, `out_valid` at cycle 5, `overflow=0`.
- a=`0x40400000` (3.0), b=`0x3F000000` (0.5) → `0x40600000` at cycle 7 (A=2).
- a=`0x3F800000`, b=`0xBF800000` → `0x00000000` (+0).
- a=`0x7F800000`, b=`0xFF800000` → `0x7FC00000` at cycle 1.
- a=b=`0x7F7FFFFF` → `0x7F800000`, `overflow=1`.
- Hold `out_ready=0` for 10 cycles, then pulse it → `sum` stable throughout, `in_ready` returns the next cycle. Assert reset in ALIGN → `out_valid=0` and IDLE immediately, and the next operation completes correctly.
- With `FP_ADD_RNE_EN`: a=`0x3F800000`, b=`0x33800000` (2^-24) → `0x3F800000` (tie to even). Add b=`0x33C00000` → `0x3F800001`.
